// File: rtl/sq_commit_arbiter.sv
// Shares the single data-cache port between retired-store drain and two load units.
// Stores retire into an in-order buffer and drain as byte-masked writes; loads are granted round-robin.
module sq_commit_arbiter #(
  parameter int WAYS       = 2,
  parameter int SB_DEPTH   = 4,
  parameter int SB_HIGH_WM = 3,
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [WAYS-1:0]                retire_valid,
  input  logic [WAYS*ADDR_W-1:0]         retire_addr,
  input  logic [WAYS*DATA_W-1:0]         retire_data,
  input  logic [WAYS*(DATA_W/8)-1:0]     retire_be,
  output logic                           retire_stall,
  input  logic [1:0]                     ld_req,
  input  logic [2*ADDR_W-1:0]            ld_addr,
  output logic [1:0]                     ld_gnt,
  output logic [1:0]                     ld_rvalid,
  output logic [DATA_W-1:0]              ld_rdata,
  output logic                           dc_req,
  output logic                           dc_we,
  output logic [ADDR_W-1:0]              dc_addr,
  output logic [DATA_W-1:0]              dc_wdata,
  output logic [DATA_W/8-1:0]            dc_be,
  input  logic                           dc_gnt,
  input  logic                           dc_rvalid,
  input  logic [DATA_W-1:0]              dc_rdata,
  output logic [$clog2(SB_DEPTH):0]      sb_count,
  output logic                           sb_empty
);

  localparam int BE_W  = DATA_W / 8;
  localparam int PTR_W = $clog2(SB_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, WR_REQ, RD_REQ, RD_WAIT} state_t;

  state_t            state_reg, state_next;
  logic [PTR_W-1:0]  head_reg, tail_reg;
  logic [CNT_W-1:0]  count_reg;
  logic              rr_reg, rr_next;
  logic              sel_reg, sel_next;
  logic [ADDR_W-1:0] rd_addr_reg, rd_addr_next;
  logic [ADDR_W-1:0] wr_addr_reg;
  logic [DATA_W-1:0] wr_data_reg;
  logic [BE_W-1:0]   wr_be_reg;
  logic [CNT_W-1:0]  enq_cnt;
  logic              deq;
  logic              load_head;

  logic [ADDR_W-1:0] sb_addr_mem [SB_DEPTH];
  logic [DATA_W-1:0] sb_data_mem [SB_DEPTH];
  logic [BE_W-1:0]   sb_be_mem   [SB_DEPTH];

  logic [ADDR_W-1:0] way_addr  [WAYS];
  logic [DATA_W-1:0] way_data  [WAYS];
  logic [BE_W-1:0]   way_be    [WAYS];
  logic [ADDR_W-1:0] ld_addr_w [2];

  genvar gi;
  generate
    for (gi = 0; gi < WAYS; gi++) begin : g_way
      assign way_addr[gi] = retire_addr[gi*ADDR_W +: ADDR_W];
      assign way_data[gi] = retire_data[gi*DATA_W +: DATA_W];
      assign way_be[gi]   = retire_be[gi*BE_W +: BE_W];
    end
    for (gi = 0; gi < 2; gi++) begin : g_ld
      assign ld_addr_w[gi] = ld_addr[gi*ADDR_W +: ADDR_W];
    end
  endgenerate

  // Retire ways are contiguous from way 0, so the enqueue count is a popcount.
  always_comb begin
    enq_cnt = '0;
    for (int w = 0; w < WAYS; w++) enq_cnt = enq_cnt + CNT_W'(retire_valid[w]);
  end

  assign retire_stall = (SB_DEPTH - int'(count_reg)) < WAYS;
  assign sb_count     = count_reg;
  assign sb_empty     = (count_reg == '0) && (state_reg != WR_REQ);

  always_comb begin
    state_next   = state_reg;
    rr_next      = rr_reg;
    sel_next     = sel_reg;
    rd_addr_next = rd_addr_reg;
    deq          = 1'b0;
    load_head    = 1'b0;
    dc_req       = 1'b0;
    dc_we        = 1'b0;
    dc_addr      = '0;
    dc_wdata     = '0;
    dc_be        = '0;
    ld_gnt       = '0;
    ld_rvalid    = '0;
    ld_rdata     = '0;
    case (state_reg)
      IDLE: begin
        if (count_reg >= CNT_W'(SB_HIGH_WM) || (ld_req == 2'b00 && count_reg != '0)) begin
          state_next = WR_REQ;
          load_head  = 1'b1;
        end else if (|ld_req) begin
          state_next   = RD_REQ;
          sel_next     = ld_req[rr_reg] ? rr_reg : ~rr_reg;
          rd_addr_next = ld_addr_w[sel_next];
        end
      end
      WR_REQ: begin
        dc_req   = 1'b1;
        dc_we    = 1'b1;
        dc_addr  = wr_addr_reg;
        dc_wdata = wr_data_reg;
        dc_be    = wr_be_reg;
        if (dc_gnt) begin
          deq        = 1'b1;
          state_next = IDLE;
        end
      end
      RD_REQ: begin
        dc_req  = 1'b1;
        dc_addr = rd_addr_reg;
        if (dc_gnt) begin
          ld_gnt[sel_reg] = 1'b1;
          rr_next         = ~sel_reg;
          state_next      = RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (dc_rvalid) begin
          ld_rvalid[sel_reg] = 1'b1;
          ld_rdata           = dc_rdata;
          state_next         = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_reg   <= IDLE;
      head_reg    <= '0;
      tail_reg    <= '0;
      count_reg   <= '0;
      rr_reg      <= 1'b0;
      sel_reg     <= 1'b0;
      rd_addr_reg <= '0;
    end else begin
      state_reg   <= state_next;
      head_reg    <= head_reg + PTR_W'(deq);
      tail_reg    <= tail_reg + enq_cnt[PTR_W-1:0];
      count_reg   <= count_reg + enq_cnt - CNT_W'(deq);
      rr_reg      <= rr_next;
      sel_reg     <= sel_next;
      rd_addr_reg <= rd_addr_next;
    end
  end

  // Head slot is never the enqueue target when entering WR_REQ (count > 0), so a registered read is safe.
  always_ff @(posedge clock) begin
    for (int w = 0; w < WAYS; w++) begin
      if (retire_valid[w]) begin
        sb_addr_mem[tail_reg + PTR_W'(w)] <= way_addr[w];
        sb_data_mem[tail_reg + PTR_W'(w)] <= way_data[w];
        sb_be_mem[tail_reg + PTR_W'(w)]   <= way_be[w];
      end
    end
    if (load_head) begin
      wr_addr_reg <= sb_addr_mem[head_reg];
      wr_data_reg <= sb_data_mem[head_reg];
      wr_be_reg   <= sb_be_mem[head_reg];
    end
  end

  retire_while_stalled: assert property (@(posedge clock) disable iff (!reset)
    !(retire_stall && (|retire_valid)));

endmodule

// File: tb/tb_sq_commit_arbiter.sv
// Randomized bench for sq_commit_arbiter: a transaction-level model predicts store order,
// occupancy, round-robin grant order and load data; each scenario task checks its own results.
module tb_sq_commit_arbiter;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  be;
  } wr_t;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [1:0]  retire_valid = '0;
  logic [63:0] retire_addr = '0;
  logic [63:0] retire_data = '0;
  logic [7:0]  retire_be = '0;
  logic        retire_stall;
  logic [1:0]  ld_req = '0;
  logic [63:0] ld_addr = '0;
  logic [1:0]  ld_gnt, ld_rvalid;
  logic [31:0] ld_rdata;
  logic        dc_req, dc_we;
  logic [31:0] dc_addr, dc_wdata;
  logic [3:0]  dc_be;
  logic        dc_gnt = 1'b0;
  logic        dc_rvalid = 1'b0;
  logic [31:0] dc_rdata = '0;
  logic [2:0]  sb_count;
  logic        sb_empty;

  sq_commit_arbiter dut (
    .clock(clock), .reset(reset),
    .retire_valid(retire_valid), .retire_addr(retire_addr), .retire_data(retire_data),
    .retire_be(retire_be), .retire_stall(retire_stall),
    .ld_req(ld_req), .ld_addr(ld_addr), .ld_gnt(ld_gnt), .ld_rvalid(ld_rvalid), .ld_rdata(ld_rdata),
    .dc_req(dc_req), .dc_we(dc_we), .dc_addr(dc_addr), .dc_wdata(dc_wdata), .dc_be(dc_be),
    .dc_gnt(dc_gnt), .dc_rvalid(dc_rvalid), .dc_rdata(dc_rdata),
    .sb_count(sb_count), .sb_empty(sb_empty)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  // Reference model state
  int   m_count = 0;
  int   m_rr = 0;
  wr_t  exp_wr[$];
  // Observations
  wr_t         obs_wr[$];
  bit          obs_kind[$];
  int          obs_gnt[$];
  logic [31:0] obs_gaddr[$];
  logic [1:0]  obs_rv_mask[$];
  logic [31:0] obs_rv_data[$];
  // Cache responder controls
  bit          gnt_en = 1'b0;
  bit          gnt_rand = 1'b0;
  bit          auto_resp = 1'b1;
  bit          force_rv = 1'b0;
  int          rd_lat = 2;
  bit          rv_pending = 1'b0;
  int          rv_timer = 0;
  logic [31:0] rv_addr = '0;

  function automatic logic [31:0] rdf(logic [31:0] a);
    return (a ^ 32'hC0DE_5A5A) + 32'd7;
  endfunction

  function automatic logic [31:0] rand_addr();
    return $urandom() & 32'hFFFF_FFFC;
  endfunction

  task automatic clear_obs();
    obs_wr.delete(); obs_kind.delete(); obs_gnt.delete(); obs_gaddr.delete();
    obs_rv_mask.delete(); obs_rv_data.delete();
  endtask

  task automatic set_way(int w, logic [31:0] a, logic [31:0] d, logic [3:0] be);
    retire_addr[w*32 +: 32] = a;
    retire_data[w*32 +: 32] = d;
    retire_be[w*4 +: 4]     = be;
  endtask

  // One clock: drive responder, record handshakes at negedge, advance to posedge+1.
  task automatic cycle();
    logic [1:0] gmask;
    gmask     = '0;
    dc_gnt    = gnt_rand ? 1'($urandom_range(0, 1)) : gnt_en;
    dc_rvalid = 1'b0;
    if (force_rv) begin
      dc_rvalid = 1'b1;
    end else if (rv_pending && auto_resp) begin
      if (rv_timer <= 1) begin
        dc_rvalid  = 1'b1;
        dc_rdata   = rdf(rv_addr);
        rv_pending = 1'b0;
      end else begin
        rv_timer--;
      end
    end
    force_rv = 1'b0;
    @(negedge clock);
    if (reset) begin
      if (dc_req && dc_gnt) begin
        obs_kind.push_back(dc_we);
        if (dc_we) begin
          obs_wr.push_back(wr_t'{dc_addr, dc_wdata, dc_be});
          m_count--;
        end else begin
          obs_gaddr.push_back(dc_addr);
          rv_pending = 1'b1;
          rv_timer   = rd_lat;
          rv_addr    = dc_addr;
        end
      end
      for (int i = 0; i < 2; i++) begin
        if (ld_gnt[i]) begin
          obs_gnt.push_back(i);
          gmask[i] = 1'b1;
          m_rr     = 1 - i;
        end
      end
      if (|ld_rvalid) begin
        obs_rv_mask.push_back(ld_rvalid);
        obs_rv_data.push_back(ld_rdata);
      end
      for (int w = 0; w < 2; w++) begin
        if (retire_valid[w]) begin
          exp_wr.push_back(wr_t'{retire_addr[w*32 +: 32], retire_data[w*32 +: 32], retire_be[w*4 +: 4]});
          m_count++;
        end
      end
    end else begin
      m_count    = 0;
      m_rr       = 0;
      rv_pending = 1'b0;
      exp_wr.delete();
    end
    @(posedge clock);
    #1;
    retire_valid = '0;
    ld_req       = ld_req & ~gmask;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    cycle();
    cycle();
    reset = 1'b1;
    checks++; if (sb_empty !== 1'b1) begin errors++; $display("FAIL reset_sb_empty: got %b expected 1", sb_empty); end
    checks++; if (dc_req !== 1'b0) begin errors++; $display("FAIL reset_dc_req: got %b expected 0", dc_req); end
    checks++; if (retire_stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", retire_stall); end
    checks++; if (sb_count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", sb_count); end
    checks++; if ({ld_gnt, ld_rvalid, dc_we, dc_addr, dc_wdata, dc_be, ld_rdata} !== '0) begin
      errors++; $display("FAIL reset_outputs: got nonzero outputs gnt=%b rv=%b addr=%h expected all 0", ld_gnt, ld_rvalid, dc_addr);
    end
    cycle();
    checks++; if (dc_req !== 1'b0 || sb_empty !== 1'b1) begin
      errors++; $display("FAIL reset_idle: got dc_req=%b sb_empty=%b expected 0/1", dc_req, sb_empty);
    end
  endtask

  task automatic test_store_drain();
    int trace[$];
    bit done;
    clear_obs();
    gnt_en = 1'b1; gnt_rand = 1'b0;
    set_way(0, 32'h100, 32'h11, 4'hF);
    set_way(1, 32'h104, 32'h22, 4'h3);
    retire_valid = 2'b11;
    cycle();
    trace.push_back(int'(sb_count));
    done = 1'b0;
    for (int k = 0; k < 20 && !done; k++) begin
      cycle();
      if (int'(sb_count) != trace[$]) trace.push_back(int'(sb_count));
      done = (m_count == 0) && (obs_wr.size() == 2);
    end
    checks++; if (!done) begin errors++; $display("FAIL drain_timeout: got %0d writes expected 2", obs_wr.size()); end
    checks++; if (trace.size() != 3 || trace[0] != 2 || trace[1] != 1 || trace[2] != 0) begin
      errors++; $display("FAIL drain_count_trace: got %p expected '{2,1,0}", trace);
    end
    checks++; if (obs_wr.size() != exp_wr.size()) begin
      errors++; $display("FAIL drain_write_count: got %0d expected %0d", obs_wr.size(), exp_wr.size());
    end
    while (obs_wr.size() > 0 && exp_wr.size() > 0) begin
      wr_t o, e;
      o = obs_wr.pop_front(); e = exp_wr.pop_front();
      checks++; if (o !== e) begin errors++; $display("FAIL drain_write: got %h/%h/%h expected %h/%h/%h", o.a, o.d, o.be, e.a, e.d, e.be); end
    end
    exp_wr.delete();
  endtask

  task automatic test_watermark();
    logic [31:0] a0;
    bit done;
    clear_obs();
    gnt_en = 1'b0; gnt_rand = 1'b0; rd_lat = 2;
    for (int b = 0; b < 2; b++) begin
      for (int w = 0; w < 2; w++) set_way(w, rand_addr(), $urandom(), 4'($urandom_range(1, 15)));
      retire_valid = 2'b11;
      cycle();
    end
    checks++; if (sb_count !== 3'(m_count)) begin errors++; $display("FAIL wm_count: got %0d expected %0d", sb_count, m_count); end
    checks++; if (retire_stall !== 1'b1) begin errors++; $display("FAIL wm_stall: got %b expected 1", retire_stall); end
    a0 = rand_addr();
    ld_addr[31:0] = a0;
    ld_req = 2'b01;
    cycle();
    cycle();
    checks++; if (dc_req !== 1'b1 || dc_we !== 1'b1) begin
      errors++; $display("FAIL wm_holds_write: got req=%b we=%b expected 1/1", dc_req, dc_we);
    end
    gnt_en = 1'b1;
    done = 1'b0;
    for (int k = 0; k < 60 && !done; k++) begin
      cycle();
      done = (m_count == 0) && (ld_req == 2'b00) && (obs_rv_mask.size() == 1) && (obs_kind.size() >= 5);
    end
    checks++; if (!done) begin errors++; $display("FAIL wm_timeout: got %0d txns expected 5", obs_kind.size()); end
    checks++; if (obs_kind.size() != 5 || obs_kind[0] != 1 || obs_kind[1] != 1 || obs_kind[2] != 0 ||
                  obs_kind[3] != 1 || obs_kind[4] != 1) begin
      errors++; $display("FAIL wm_txn_order: got %p expected '{1,1,0,1,1} (1=write)", obs_kind);
    end
    if (obs_gnt.size() > 0 && obs_rv_data.size() > 0) begin
      checks++; if (obs_gnt[0] != 0 || obs_rv_data[0] !== rdf(a0)) begin
        errors++; $display("FAIL wm_load: got unit %0d data %h expected unit 0 data %h", obs_gnt[0], obs_rv_data[0], rdf(a0));
      end
    end
    checks++; if (obs_wr.size() != 4 || exp_wr.size() != 4) begin
      errors++; $display("FAIL wm_write_count: got %0d expected 4", obs_wr.size());
    end
    while (obs_wr.size() > 0 && exp_wr.size() > 0) begin
      wr_t o, e;
      o = obs_wr.pop_front(); e = exp_wr.pop_front();
      checks++; if (o !== e) begin errors++; $display("FAIL wm_write: got %h/%h/%h expected %h/%h/%h", o.a, o.d, o.be, e.a, e.d, e.be); end
    end
    exp_wr.delete();
  endtask

  task automatic test_round_robin();
    logic [31:0] q0[$], q1[$];
    logic [31:0] a, ea;
    int start, eu;
    bit done;
    clear_obs();
    gnt_en = 1'b1; gnt_rand = 1'b0; rd_lat = 2;
    start = m_rr;
    a = rand_addr(); ld_addr[31:0]  = a; q0.push_back(a);
    a = rand_addr(); ld_addr[63:32] = a; q1.push_back(a);
    ld_req = 2'b11;
    done = 1'b0;
    for (int k = 0; k < 200 && !done; k++) begin
      cycle();
      for (int i = 0; i < 2; i++) begin
        if (!ld_req[i] && obs_gnt.size() < 4) begin
          a = rand_addr();
          ld_addr[i*32 +: 32] = a;
          if (i == 0) q0.push_back(a); else q1.push_back(a);
          ld_req[i] = 1'b1;
        end
      end
      done = (obs_gnt.size() >= 4) && (ld_req == 2'b00) && (obs_rv_mask.size() == obs_gnt.size());
    end
    checks++; if (!done || obs_gnt.size() != 5) begin
      errors++; $display("FAIL rr_grant_count: got %0d expected 5", obs_gnt.size());
    end
    for (int j = 0; j < obs_gnt.size() && j < obs_rv_mask.size() && j < obs_gaddr.size(); j++) begin
      eu = (start + j) % 2;
      ea = (eu == 0) ? ((q0.size() > 0) ? q0.pop_front() : 32'hx) : ((q1.size() > 0) ? q1.pop_front() : 32'hx);
      checks++; if (obs_gnt[j] != eu) begin errors++; $display("FAIL rr_unit[%0d]: got %0d expected %0d", j, obs_gnt[j], eu); end
      checks++; if (obs_gaddr[j] !== ea) begin errors++; $display("FAIL rr_addr[%0d]: got %h expected %h", j, obs_gaddr[j], ea); end
      checks++; if (obs_rv_mask[j] !== 2'(1 << eu)) begin errors++; $display("FAIL rr_rvalid[%0d]: got %b expected %b", j, obs_rv_mask[j], 2'(1 << eu)); end
      checks++; if (obs_rv_data[j] !== rdf(ea)) begin errors++; $display("FAIL rr_rdata[%0d]: got %h expected %h", j, obs_rv_data[j], rdf(ea)); end
    end
  endtask

  task automatic test_wrap();
    int bursts;
    clear_obs();
    gnt_rand = 1'b1;
    bursts = 0;
    for (int k = 0; k < 400 && (bursts < 5 || m_count > 0); k++) begin
      if (bursts < 5 && !retire_stall && $urandom_range(0, 1) == 1) begin
        for (int w = 0; w < 2; w++) set_way(w, rand_addr(), $urandom(), 4'($urandom_range(0, 15)));
        retire_valid = 2'b11;
        bursts++;
      end
      cycle();
      checks++; if (sb_count !== 3'(m_count)) begin errors++; $display("FAIL wrap_count: got %0d expected %0d", sb_count, m_count); end
    end
    gnt_rand = 1'b0;
    checks++; if (bursts != 5 || m_count != 0) begin errors++; $display("FAIL wrap_timeout: got %0d bursts, %0d left expected 5, 0", bursts, m_count); end
    checks++; if (obs_wr.size() != 10 || exp_wr.size() != 10) begin
      errors++; $display("FAIL wrap_write_count: got %0d expected 10", obs_wr.size());
    end
    while (obs_wr.size() > 0 && exp_wr.size() > 0) begin
      wr_t o, e;
      o = obs_wr.pop_front(); e = exp_wr.pop_front();
      checks++; if (o !== e) begin errors++; $display("FAIL wrap_write: got %h/%h/%h expected %h/%h/%h", o.a, o.d, o.be, e.a, e.d, e.be); end
    end
    exp_wr.delete();
    checks++; if (sb_empty !== 1'b1) begin errors++; $display("FAIL wrap_empty: got %b expected 1", sb_empty); end
  endtask

  task automatic test_reset_mid();
    bit done;
    clear_obs();
    auto_resp = 1'b0; gnt_en = 1'b1; gnt_rand = 1'b0;
    ld_addr[63:32] = rand_addr();
    ld_req = 2'b10;
    for (int k = 0; k < 20 && obs_gnt.size() == 0; k++) cycle();
    checks++; if (obs_gnt.size() != 1) begin errors++; $display("FAIL mid_grant: got %0d grants expected 1", obs_gnt.size()); end
    gnt_en = 1'b0;
    for (int w = 0; w < 2; w++) set_way(w, rand_addr(), $urandom(), 4'hF);
    retire_valid = 2'b11;
    cycle();
    checks++; if (sb_count !== 3'd2) begin errors++; $display("FAIL mid_count_before: got %0d expected 2", sb_count); end
    reset = 1'b0;
    cycle();
    cycle();
    reset = 1'b1;
    checks++; if (sb_count !== 3'd0) begin errors++; $display("FAIL mid_count: got %0d expected 0", sb_count); end
    checks++; if (dc_req !== 1'b0 || sb_empty !== 1'b1) begin errors++; $display("FAIL mid_idle: got req=%b empty=%b expected 0/1", dc_req, sb_empty); end
    dc_rdata = $urandom();
    force_rv = 1'b1;
    cycle();
    checks++; if (obs_rv_mask.size() != 0) begin errors++; $display("FAIL mid_stale_rvalid: got %0d pulses expected 0", obs_rv_mask.size()); end
    checks++; if (dc_req !== 1'b0) begin errors++; $display("FAIL mid_after_rvalid: got dc_req=%b expected 0", dc_req); end
    auto_resp = 1'b1; gnt_en = 1'b1;
    clear_obs();
    ld_addr[31:0]  = rand_addr();
    ld_addr[63:32] = rand_addr();
    ld_req = 2'b11;
    done = 1'b0;
    for (int k = 0; k < 40 && !done; k++) begin
      cycle();
      done = (ld_req == 2'b00) && (obs_rv_mask.size() == 2);
    end
    checks++; if (!done || obs_gnt.size() != 2 || obs_gnt[0] != 0 || obs_gnt[1] != 1) begin
      errors++; $display("FAIL mid_rr_reset: got %p expected '{0,1}", obs_gnt);
    end
  endtask

  initial begin
    test_reset();
    test_store_drain();
    test_watermark();
    test_round_robin();
    test_wrap();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
